// File: rtl/escalonador_requisicoes_pkg.sv
// escalonador_pkg: shared definitions for the request scheduler.
//   - 3-bit FSM state encoding (legacy-compatible localparams)
//   - default parameter values
//   - idx_width(): index width helper for the requester count
package escalonador_pkg;

  localparam int unsigned ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ESTADO_W-1:0] ST_DISPARAR  = 3'd1;
  localparam logic [ESTADO_W-1:0] ST_EXECUTAR  = 3'd2;
  localparam logic [ESTADO_W-1:0] ST_RESPONDER = 3'd3;
  localparam logic [ESTADO_W-1:0] ST_LIBERAR   = 3'd4;

  localparam int unsigned NUM_REQ_PADRAO      = 4;
  localparam int unsigned ADDR_WIDTH_PADRAO   = 16;
  localparam int unsigned CICLOS_WIDTH_PADRAO = 24;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/escalonador_requisicoes_if.sv
// escalonador_requisicoes_if: host-side request/response bundle.
//   req_valid_in    per-requester pending request (level)
//   req_fonte_in    packed source nodes, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_destino_in  packed destination nodes, same packing
//   req_aceito_out  one-hot accept pulse
//   resp_valid_out  one-hot result-ready level
//   resp_lido_in    per-requester result consumed
//   resp_ciclos_out measured execution cycles
// master: requester side; slave: scheduler side.
interface escalonador_requisicoes_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned CICLOS_WIDTH = 24
);

  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_fonte_in;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_destino_in;
  logic [NUM_REQ-1:0]            req_aceito_out;
  logic [NUM_REQ-1:0]            resp_valid_out;
  logic [NUM_REQ-1:0]            resp_lido_in;
  logic [CICLOS_WIDTH-1:0]       resp_ciclos_out;

  modport master (
    output req_valid_in,
    output req_fonte_in,
    output req_destino_in,
    output resp_lido_in,
    input  req_aceito_out,
    input  resp_valid_out,
    input  resp_ciclos_out
  );

  modport slave (
    input  req_valid_in,
    input  req_fonte_in,
    input  req_destino_in,
    input  resp_lido_in,
    output req_aceito_out,
    output resp_valid_out,
    output resp_ciclos_out
  );

endinterface

// File: rtl/escalonador_requisicoes_arbitro_round_robin.sv
// arbitro_round_robin: combinational round-robin search.
//   req        pending requests
//   ptr        last served requester (lowest priority this round)
//   grant      one-hot winner
//   grant_idx  winner index
//   valid      some request is pending
module arbitro_round_robin
  import escalonador_pkg::*;
#(
  parameter int unsigned  NUM_REQ = NUM_REQ_PADRAO,
  localparam int unsigned ID_W    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               valid
);

  logic        found;
  int unsigned cand;

  // Cyclic search starting at ptr+1; ptr itself is visited last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[ID_W'(cand)]) begin
        found              = 1'b1;
        grant[ID_W'(cand)] = 1'b1;
        grant_idx          = ID_W'(cand);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/escalonador_requisicoes.sv
// escalonador_requisicoes: round-robin scheduler sharing one path-finding
// controller between NUM_REQ host requesters.
//   clk, rst                clock, synchronous active-high reset
//   host (slave modport)    request/response bundle towards requesters
//   ctrl_aguardando_in      controller idle
//   ctrl_caminho_pronto_in  controller path complete
//   ctrl_iniciar_out        1-cycle start pulse
//   ctrl_lido_out           1-cycle result-consumed pulse
//   fonte_out, destino_out  latched operands of the current owner
//   ocupado_out             scheduler not idle
//   grant_id_out            index of current owner
// Every output is a flop; the next values are decoded together with the
// next state so each pulse lands in the cycle of the state it belongs to.
module escalonador_requisicoes
  import escalonador_pkg::*;
#(
  parameter int unsigned  NUM_REQ      = NUM_REQ_PADRAO,
  parameter int unsigned  ADDR_WIDTH   = ADDR_WIDTH_PADRAO,
  parameter int unsigned  CICLOS_WIDTH = CICLOS_WIDTH_PADRAO,
  localparam int unsigned ID_W         = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  escalonador_requisicoes_if.slave      host,
  input  logic                          ctrl_aguardando_in,
  input  logic                          ctrl_caminho_pronto_in,
  output logic                          ctrl_iniciar_out,
  output logic                          ctrl_lido_out,
  output logic [ADDR_WIDTH-1:0]         fonte_out,
  output logic [ADDR_WIDTH-1:0]         destino_out,
  output logic                          ocupado_out,
  output logic [ID_W-1:0]               grant_id_out
);

  localparam logic [CICLOS_WIDTH-1:0] CICLOS_MAX = '1;

  logic [ESTADO_W-1:0]     state, state_d;
  logic [ID_W-1:0]         ptr, ptr_d;
  logic [ID_W-1:0]         grant_id_d;
  logic [ADDR_WIDTH-1:0]   fonte_d, destino_d;
  logic [CICLOS_WIDTH-1:0] cnt, cnt_d;
  logic [NUM_REQ-1:0]      aceito_q, aceito_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [CICLOS_WIDTH-1:0] resp_ciclos_q, resp_ciclos_d;
  logic                    iniciar_d, lido_d, ocupado_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [ID_W-1:0]         arb_idx;
  logic                    arb_valid;

  arbitro_round_robin #(
    .NUM_REQ   (NUM_REQ)
  ) u_arbitro (
    .req       (host.req_valid_in),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    grant_id_d    = grant_id_out;
    fonte_d       = fonte_out;
    destino_d     = destino_out;
    cnt_d         = cnt;
    aceito_d      = '0;
    iniciar_d     = 1'b0;
    lido_d        = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_ciclos_d = resp_ciclos_q;

    case (state)
      ST_IDLE: begin
        if (ctrl_aguardando_in && arb_valid) begin
          state_d    = ST_DISPARAR;
          grant_id_d = arb_idx;
          fonte_d    = host.req_fonte_in[32'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          destino_d  = host.req_destino_in[32'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          aceito_d   = arb_grant;
        end
      end

      // First cycle shows the accept pulse, second cycle the start pulse.
      ST_DISPARAR: begin
        cnt_d = '0;
        if (!ctrl_iniciar_out) begin
          iniciar_d = 1'b1;
        end else begin
          state_d = ST_EXECUTAR;
        end
      end

      // Counts cycles without completion, saturating instead of wrapping.
      ST_EXECUTAR: begin
        if (ctrl_caminho_pronto_in) begin
          state_d       = ST_RESPONDER;
          resp_valid_d  = NUM_REQ'(1) << grant_id_out;
          resp_ciclos_d = cnt;
        end else if (cnt != CICLOS_MAX) begin
          cnt_d = cnt + CICLOS_WIDTH'(1);
        end
      end

      // Only the owner's consume bit matters.
      ST_RESPONDER: begin
        if (host.resp_lido_in[grant_id_out]) begin
          state_d       = ST_LIBERAR;
          lido_d        = 1'b1;
          resp_valid_d  = '0;
          resp_ciclos_d = '0;
        end
      end

      ST_LIBERAR: begin
        state_d = ST_IDLE;
        ptr_d   = grant_id_out;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ocupado_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      ptr              <= ID_W'(NUM_REQ - 1);
      grant_id_out     <= '0;
      fonte_out        <= '0;
      destino_out      <= '0;
      cnt              <= '0;
      aceito_q         <= '0;
      resp_valid_q     <= '0;
      resp_ciclos_q    <= '0;
      ctrl_iniciar_out <= 1'b0;
      ctrl_lido_out    <= 1'b0;
      ocupado_out      <= 1'b0;
    end else begin
      state            <= state_d;
      ptr              <= ptr_d;
      grant_id_out     <= grant_id_d;
      fonte_out        <= fonte_d;
      destino_out      <= destino_d;
      cnt              <= cnt_d;
      aceito_q         <= aceito_d;
      resp_valid_q     <= resp_valid_d;
      resp_ciclos_q    <= resp_ciclos_d;
      ctrl_iniciar_out <= iniciar_d;
      ctrl_lido_out    <= lido_d;
      ocupado_out      <= ocupado_d;
    end
  end

  assign host.req_aceito_out  = aceito_q;
  assign host.resp_valid_out  = resp_valid_q;
  assign host.resp_ciclos_out = resp_ciclos_q;

endmodule

// File: tb/tb_escalonador_requisicoes.sv
// Scoreboard bench for escalonador_requisicoes (NUM_REQ=4, ADDR_WIDTH=16,
// CICLOS_WIDTH=4). Stimulus pushes expected accepts/responses; a monitor
// pops and compares whenever the DUT presents them.
module tb_escalonador_requisicoes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aguardando = 1'b0;
  logic        pronto = 1'b0;
  logic        iniciar;
  logic        lido;
  logic [15:0] fonte;
  logic [15:0] destino;
  logic        ocupado;
  logic [1:0]  grant_id;

  int testes = 0;
  int falhas = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [3:0]  oh;
    logic [15:0] f;
    logic [15:0] d;
  } acc_t;

  typedef struct packed {
    logic [3:0] oh;
    logic [3:0] ciclos;
  } resp_t;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];

  logic [15:0] fonte_tab   [4];
  logic [15:0] destino_tab [4];

  escalonador_requisicoes_if #(.NUM_REQ(4), .ADDR_WIDTH(16), .CICLOS_WIDTH(4)) bus ();

  escalonador_requisicoes #(.NUM_REQ(4), .ADDR_WIDTH(16), .CICLOS_WIDTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .host                   (bus),
    .ctrl_aguardando_in     (aguardando),
    .ctrl_caminho_pronto_in (pronto),
    .ctrl_iniciar_out       (iniciar),
    .ctrl_lido_out          (lido),
    .fonte_out              (fonte),
    .destino_out            (destino),
    .ocupado_out            (ocupado),
    .grant_id_out           (grant_id)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nome, input logic [63:0] atual,
                                input logic [63:0] esperado);
    testes++;
    if (atual !== esperado) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endfunction

  task automatic carregar_operandos();
    for (int i = 0; i < 4; i++) begin
      bus.req_fonte_in[i*16 +: 16]   = fonte_tab[i];
      bus.req_destino_in[i*16 +: 16] = destino_tab[i];
    end
  endtask

  // Monitor: pops the scoreboard whenever an accept or a new response shows up.
  acc_t       m_acc;
  resp_t      m_resp;
  logic [3:0] resp_ant = 4'b0;

  always @(negedge clk) begin
    if (bus.req_aceito_out != 4'b0) begin
      if (exp_acc.size() == 0) begin
        check("aceito_inesperado", 64'(bus.req_aceito_out), 64'd0);
      end else begin
        m_acc = exp_acc.pop_front();
        check("aceito_onehot", 64'(bus.req_aceito_out), 64'(m_acc.oh));
        check("grant_id", 64'(grant_id), 64'(m_acc.idx));
        check("fonte", 64'(fonte), 64'(m_acc.f));
        check("destino", 64'(destino), 64'(m_acc.d));
        check("ocupado_aceito", 64'(ocupado), 64'd1);
      end
    end
    if (bus.resp_valid_out != 4'b0 && resp_ant == 4'b0) begin
      if (exp_resp.size() == 0) begin
        check("resp_inesperada", 64'(bus.resp_valid_out), 64'd0);
      end else begin
        m_resp = exp_resp.pop_front();
        check("resp_valid", 64'(bus.resp_valid_out), 64'(m_resp.oh));
        check("resp_ciclos", 64'(bus.resp_ciclos_out), 64'(m_resp.ciclos));
      end
    end
    resp_ant = bus.resp_valid_out;
  end

  // One full transaction for requester g; caller has set requests and aguardando.
  task automatic transacao(input int g, input int n_exec, input logic [3:0] exp_ciclos,
                           input bit soltar, input bit lido_errado);
    acc_t       a;
    resp_t      r;
    bit         got;
    logic [3:0] outro;
    a.idx = 2'(g);
    a.oh  = 4'b0001 << g;
    a.f   = fonte_tab[g];
    a.d   = destino_tab[g];
    exp_acc.push_back(a);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.req_aceito_out != 4'b0) got = 1'b1;
    end
    check("aceito_timeout", 64'(got), 64'd1);
    if (!got) return;
    if (soltar) bus.req_valid_in[g] = 1'b0;
    @(negedge clk);
    check("iniciar_pulso", 64'(iniciar), 64'd1);
    check("aceito_unico", 64'(bus.req_aceito_out), 64'd0);
    aguardando = 1'b0;
    @(negedge clk);
    check("iniciar_fim", 64'(iniciar), 64'd0);
    for (int k = 0; k < n_exec; k++) begin
      pronto = 1'b0;
      @(negedge clk);
    end
    pronto = 1'b1;
    r.oh     = a.oh;
    r.ciclos = exp_ciclos;
    exp_resp.push_back(r);
    @(negedge clk);
    pronto = 1'b0;
    if (lido_errado) begin
      outro = (a.oh == 4'b1000) ? 4'b0001 : 4'b1000;
      bus.resp_lido_in = outro;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("lido_errado_resp", 64'(bus.resp_valid_out), 64'(a.oh));
        check("lido_errado_ctrl", 64'(lido), 64'd0);
      end
    end
    bus.resp_lido_in = a.oh;
    @(negedge clk);
    bus.resp_lido_in = 4'b0;
    check("ctrl_lido_pulso", 64'(lido), 64'd1);
    check("resp_valid_baixa", 64'(bus.resp_valid_out), 64'd0);
    check("ocupado_liberar", 64'(ocupado), 64'd1);
    @(negedge clk);
    check("ctrl_lido_fim", 64'(lido), 64'd0);
    check("ocupado_idle", 64'(ocupado), 64'd0);
    aguardando = 1'b1;
  endtask

  task automatic checar_zerado(input string nome);
    check({nome, "_aceito"}, 64'(bus.req_aceito_out), 64'd0);
    check({nome, "_resp"}, 64'(bus.resp_valid_out), 64'd0);
    check({nome, "_ciclos"}, 64'(bus.resp_ciclos_out), 64'd0);
    check({nome, "_iniciar"}, 64'(iniciar), 64'd0);
    check({nome, "_lido"}, 64'(lido), 64'd0);
    check({nome, "_fonte"}, 64'(fonte), 64'd0);
    check({nome, "_destino"}, 64'(destino), 64'd0);
    check({nome, "_ocupado"}, 64'(ocupado), 64'd0);
    check({nome, "_grant"}, 64'(grant_id), 64'd0);
  endtask

  initial begin
    acc_t a;
    int   n_aceito;
    bit   got;
    bus.req_valid_in   = 4'b0;
    bus.req_fonte_in   = '0;
    bus.req_destino_in = '0;
    bus.resp_lido_in   = 4'b0;
    fonte_tab   = '{16'h0100, 16'h0101, 16'h0010, 16'h0103};
    destino_tab = '{16'h0200, 16'h0201, 16'h0020, 16'h0203};
    carregar_operandos();

    // Reset state.
    repeat (2) @(negedge clk);
    checar_zerado("reset");
    rst = 1'b0;
    aguardando = 1'b1;

    // Single request from requester 2, 5 execution cycles.
    bus.req_valid_in = 4'b0100;
    transacao(2, 5, 4'd5, 1'b1, 1'b0);

    // Restart, then all four requesting continuously: 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_in = 4'b1111;
    transacao(0, 3, 4'd3, 1'b0, 1'b0);
    transacao(1, 1, 4'd1, 1'b0, 1'b0);
    transacao(2, 0, 4'd0, 1'b0, 1'b0);
    transacao(3, 2, 4'd2, 1'b0, 1'b0);
    transacao(0, 4, 4'd4, 1'b0, 1'b0);
    bus.req_valid_in = 4'b0;

    // Controller busy for 10 cycles: no accept; then requester 1 wins.
    aguardando = 1'b0;
    bus.req_valid_in = 4'b1010;
    n_aceito = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req_aceito_out != 4'b0) n_aceito++;
    end
    check("sem_aceito_ocupado", 64'(n_aceito), 64'd0);
    check("idle_esperando", 64'(ocupado), 64'd0);
    aguardando = 1'b1;
    transacao(1, 2, 4'd2, 1'b1, 1'b0);
    bus.req_valid_in = 4'b0;

    // Consume bit from a non-owner is ignored.
    bus.req_valid_in = 4'b0001;
    transacao(0, 2, 4'd2, 1'b1, 1'b1);

    // Counter saturates at 15 with CICLOS_WIDTH=4.
    bus.req_valid_in = 4'b0001;
    transacao(0, 19, 4'd15, 1'b1, 1'b0);

    // Reset during execution of requester 1.
    bus.req_valid_in = 4'b0010;
    a.idx = 2'd1;
    a.oh  = 4'b0010;
    a.f   = fonte_tab[1];
    a.d   = destino_tab[1];
    exp_acc.push_back(a);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.req_aceito_out != 4'b0) got = 1'b1;
    end
    check("aceito_timeout_rst", 64'(got), 64'd1);
    bus.req_valid_in = 4'b0;
    @(negedge clk);
    aguardando = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checar_zerado("reset_meio");
    rst = 1'b0;
    aguardando = 1'b1;
    bus.req_valid_in = 4'b1111;
    transacao(0, 1, 4'd1, 1'b0, 1'b0);
    bus.req_valid_in = 4'b0;

    repeat (3) @(negedge clk);
    check("fila_aceito_vazia", 64'(exp_acc.size()), 64'd0);
    check("fila_resp_vazia", 64'(exp_resp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
